// File: rtl/obi_mem_arbiter.sv
// N-to-1 OBI arbiter with an in-order routing FIFO that steers responses back to their requester.
// Optional build macro OBI_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module obi_mem_arbiter #(
    parameter int unsigned NUM_PORTS       = 3,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,

    input  logic [NUM_PORTS-1:0]                   m_req_i,
    output logic [NUM_PORTS-1:0]                   m_gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]        m_addr_i,
    input  logic [NUM_PORTS-1:0]                   m_we_i,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]    m_be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]        m_wdata_i,
    output logic [NUM_PORTS-1:0]                   m_rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]        m_rdata_o,

    output logic                                   s_req_o,
    output logic [ADDR_WIDTH-1:0]                  s_addr_o,
    output logic                                   s_we_o,
    output logic [DATA_WIDTH/8-1:0]                s_be_o,
    output logic [DATA_WIDTH-1:0]                  s_wdata_o,
    input  logic                                   s_gnt_i,
    input  logic                                   s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  s_rdata_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                 locked_q;
    logic [IDX_W-1:0]     lock_idx_q;
    logic [IDX_W-1:0]     fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 err_q;

    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_found;
    logic                 sel_valid;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 handshake;
    logic                 pop;
    logic [IDX_W-1:0]     head_idx;

`ifndef OBI_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]     rr_q;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);
    assign head_idx   = fifo_q[rd_ptr_q];

    // Port selection: a pending (ungranted) address phase keeps its port until the handshake.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        if (locked_q) begin
            sel_idx   = lock_idx_q;
            sel_found = m_req_i[lock_idx_q];
        end else begin
`ifdef OBI_ARB_FIXED_PRIO_EN
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!sel_found && m_req_i[IDX_W'(i)]) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end
`else
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!sel_found && m_req_i[IDX_W'((32'(rr_q) + i) % NUM_PORTS)]) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'((32'(rr_q) + i) % NUM_PORTS);
                end
            end
`endif
        end
    end

    // No request leaves while the routing FIFO is full or while in reset.
    assign sel_valid = sel_found && !fifo_full && !rst_i;
    assign handshake = sel_valid && s_gnt_i;
    assign pop       = s_rvalid_i && !fifo_empty && !rst_i;

    always_comb begin
        s_req_o   = sel_valid;
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        if (sel_valid) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                if (IDX_W'(k) == sel_idx) begin
                    s_addr_o  = m_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                    s_we_o    = m_we_i[k];
                    s_be_o    = m_be_i[k*BE_W +: BE_W];
                    s_wdata_o = m_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (handshake) begin
            m_gnt_o = NUM_PORTS'(1) << sel_idx;
        end
        if (pop) begin
            m_rvalid_o = NUM_PORTS'(1) << head_idx;
        end
    end

    assign m_rdata_o     = {NUM_PORTS{s_rdata_i}};
    assign outstanding_o = count_q;
    assign err_o         = err_q;

    // Control state: lock, FIFO pointers/occupancy, sticky error, priority pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked_q   <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
`ifndef OBI_ARB_FIXED_PRIO_EN
            rr_q       <= '0;
`endif
        end else begin
            if (handshake) begin
                locked_q <= 1'b0;
            end else if (s_req_o) begin
                locked_q   <= 1'b1;
                lock_idx_q <= sel_idx;
            end

            if (handshake) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end

            case ({handshake, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            if (s_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end

`ifndef OBI_ARB_FIXED_PRIO_EN
            if (handshake) begin
                rr_q <= (sel_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : sel_idx + IDX_W'(1);
            end
`endif
        end
    end

    // Routing FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_q[wr_ptr_q] <= sel_idx;
        end
    end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed self-checking bench for obi_mem_arbiter (3 ports, 32-bit, two outstanding).
module tb_obi_mem_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    m_req = '0;
    logic [N-1:0]    m_gnt;
    logic [N*AW-1:0] m_addr = '0;
    logic [N-1:0]    m_we = '0;
    logic [N*BW-1:0] m_be = '0;
    logic [N*DW-1:0] m_wdata = '0;
    logic [N-1:0]    m_rvalid;
    logic [N*DW-1:0] m_rdata;
    logic            s_req;
    logic [AW-1:0]   s_addr;
    logic            s_we;
    logic [BW-1:0]   s_be;
    logic [DW-1:0]   s_wdata;
    logic            s_gnt = 1'b0;
    logic            s_rvalid = 1'b0;
    logic [DW-1:0]   s_rdata = '0;
    logic [1:0]      outstanding;
    logic            err;

    int total = 0;
    int bad   = 0;

    obi_mem_arbiter #(
        .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
        .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be),
        .s_wdata_o(s_wdata), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; m_req = 3'b111; s_gnt = 1'b1; s_rvalid = 1'b1;
        tick; tick; #1;
        total++; if (s_req !== 1'b0) begin bad++; $display("FAIL reset_s_req: got %b want 0", s_req); end
        total++; if (m_gnt !== 3'b000) begin bad++; $display("FAIL reset_m_gnt: got %b want 000", m_gnt); end
        total++; if (m_rvalid !== 3'b000) begin bad++; $display("FAIL reset_m_rvalid: got %b want 000", m_rvalid); end
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; rst = 1'b0;
        tick;
    endtask

`ifdef OBI_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio;
        m_req = 3'b101; s_gnt = 1'b1;
        for (int j = 0; j < 6; j++) begin
            s_rvalid = (j > 0);
            #1;
            total++; if (m_gnt !== 3'b001) begin bad++; $display("FAIL fixed_gnt[%0d]: got %b want 001", j, m_gnt); end
            if (j > 0) begin
                total++; if (m_rvalid !== 3'b001) begin bad++; $display("FAIL fixed_rvalid[%0d]: got %b want 001", j, m_rvalid); end
            end
            tick;
        end
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
        tick;
        s_rvalid = 1'b0; #1;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL fixed_drain: got %0d want 0", outstanding); end
    endtask
`else
    task automatic test_round_robin;
        logic [2:0] exp_g [6];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        m_req = 3'b111; s_gnt = 1'b1;
        for (int j = 0; j < 6; j++) begin
            s_rvalid = (j > 0);
            #1;
            total++; if (m_gnt !== exp_g[j]) begin bad++; $display("FAIL rr_gnt[%0d]: got %b want %b", j, m_gnt, exp_g[j]); end
            if (j > 0) begin
                total++; if (m_rvalid !== exp_g[j-1]) begin bad++; $display("FAIL rr_rvalid[%0d]: got %b want %b", j, m_rvalid, exp_g[j-1]); end
            end
            tick;
        end
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; #1;
        total++; if (m_rvalid !== 3'b100) begin bad++; $display("FAIL rr_last_rvalid: got %b want 100", m_rvalid); end
        tick;
        s_rvalid = 1'b0; #1;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL rr_drain: got %0d want 0", outstanding); end
    endtask
`endif

    task automatic test_lock;
        m_addr[0*AW +: AW] = 32'h1000_0000;
        m_addr[2*AW +: AW] = 32'h3000_0000;
        m_req = 3'b100; s_gnt = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            total++; if (s_req !== 1'b1 || s_addr !== 32'h3000_0000 || m_gnt !== 3'b000) begin
                bad++; $display("FAIL lock_wait[%0d]: got req=%b addr=%h gnt=%b want 1 30000000 000", j, s_req, s_addr, m_gnt);
            end
            tick;
        end
        m_req = 3'b101; #1;
        total++; if (s_addr !== 32'h3000_0000) begin bad++; $display("FAIL lock_hold_addr: got %h want 30000000", s_addr); end
        tick;
        s_gnt = 1'b1; #1;
        total++; if (m_gnt !== 3'b100 || s_addr !== 32'h3000_0000) begin
            bad++; $display("FAIL lock_grant: got gnt=%b addr=%h want 100 30000000", m_gnt, s_addr);
        end
        tick;
        m_req = 3'b001; #1;
        total++; if (m_gnt !== 3'b001 || s_addr !== 32'h1000_0000) begin
            bad++; $display("FAIL lock_next: got gnt=%b addr=%h want 001 10000000", m_gnt, s_addr);
        end
        tick;
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; #1;
        total++; if (m_rvalid !== 3'b100) begin bad++; $display("FAIL lock_rsp0: got %b want 100", m_rvalid); end
        tick; #1;
        total++; if (m_rvalid !== 3'b001) begin bad++; $display("FAIL lock_rsp1: got %b want 001", m_rvalid); end
        tick;
        s_rvalid = 1'b0; #1;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL lock_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_single;
        m_addr[1*AW +: AW] = 32'h0200_0000;
        m_req = 3'b010; m_we = '0; s_gnt = 1'b1; #1;
        total++; if (m_gnt !== 3'b010) begin bad++; $display("FAIL single_gnt: got %b want 010", m_gnt); end
        total++; if (s_addr !== 32'h0200_0000 || s_we !== 1'b0) begin
            bad++; $display("FAIL single_addr: got %h we=%b want 02000000 we=0", s_addr, s_we);
        end
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL single_occ0: got %0d want 0", outstanding); end
        tick;
        m_req = '0; s_gnt = 1'b0; #1;
        total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL single_occ1: got %0d want 1", outstanding); end
        s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; #1;
        total++; if (m_rvalid !== 3'b010) begin bad++; $display("FAIL single_rvalid: got %b want 010", m_rvalid); end
        total++; if (m_rdata[1*DW +: DW] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single_rdata: got %h want deadbeef", m_rdata[1*DW +: DW]);
        end
        tick;
        s_rvalid = 1'b0; #1;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL single_occ_end: got %0d want 0", outstanding); end
    endtask

    task automatic test_write_mux;
        m_addr[2*AW +: AW] = 32'h3000_0010;
        m_we = 3'b100; m_be[2*BW +: BW] = 4'b0011; m_wdata[2*DW +: DW] = 32'hCAFE_F00D;
        m_req = 3'b100; s_gnt = 1'b1; #1;
        total++; if (s_we !== 1'b1 || s_be !== 4'b0011 || s_wdata !== 32'hCAFE_F00D || s_addr !== 32'h3000_0010) begin
            bad++; $display("FAIL wr_fields: got we=%b be=%b wdata=%h addr=%h want 1 0011 cafef00d 30000010", s_we, s_be, s_wdata, s_addr);
        end
        tick;
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; #1;
        total++; if (s_req !== 1'b0 || s_addr !== '0 || s_be !== '0 || s_wdata !== '0 || s_we !== 1'b0) begin
            bad++; $display("FAIL idle_fields: got req=%b addr=%h be=%b wdata=%h we=%b want all 0", s_req, s_addr, s_be, s_wdata, s_we);
        end
        total++; if (m_rvalid !== 3'b100) begin bad++; $display("FAIL wr_rvalid: got %b want 100", m_rvalid); end
        tick;
        s_rvalid = 1'b0; m_we = '0;
    endtask

    task automatic test_throttle;
        m_req = 3'b001; s_gnt = 1'b1; #1;
        total++; if (m_gnt !== 3'b001) begin bad++; $display("FAIL thr_gnt_a: got %b want 001", m_gnt); end
        tick; #1;
        total++; if (m_gnt !== 3'b001) begin bad++; $display("FAIL thr_gnt_b: got %b want 001", m_gnt); end
        tick; #1;
        total++; if (s_req !== 1'b0 || m_gnt !== 3'b000 || outstanding !== 2'd2) begin
            bad++; $display("FAIL thr_full: got req=%b gnt=%b occ=%0d want 0 000 2", s_req, m_gnt, outstanding);
        end
        tick;
        s_rvalid = 1'b1; #1;
        total++; if (s_req !== 1'b0 || m_rvalid !== 3'b001) begin
            bad++; $display("FAIL thr_no_bypass: got req=%b rvalid=%b want 0 001", s_req, m_rvalid);
        end
        tick;
        s_rvalid = 1'b0; #1;
        total++; if (outstanding !== 2'd1 || m_gnt !== 3'b001) begin
            bad++; $display("FAIL thr_resume: got occ=%0d gnt=%b want 1 001", outstanding, m_gnt);
        end
        tick;
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
        tick; tick;
        s_rvalid = 1'b0; #1;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL thr_drain: got %0d want 0", outstanding); end
    endtask

    task automatic test_unexpected_rsp;
        s_rvalid = 1'b1; #1;
        total++; if (m_rvalid !== 3'b000 || err !== 1'b0) begin
            bad++; $display("FAIL oob_same_cycle: got rvalid=%b err=%b want 000 0", m_rvalid, err);
        end
        tick;
        s_rvalid = 1'b0; #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL oob_err_set: got %b want 1", err); end
        tick; tick;
        total++; if (err !== 1'b1 || outstanding !== 2'd0) begin
            bad++; $display("FAIL oob_err_sticky: got err=%b occ=%0d want 1 0", err, outstanding);
        end
        rst = 1'b1;
        tick;
        total++; if (err !== 1'b0) begin bad++; $display("FAIL oob_err_clear: got %b want 0", err); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_reset_flush;
        m_req = 3'b010; s_gnt = 1'b1;
        tick;
        m_req = '0; s_gnt = 1'b0; #1;
        total++; if (outstanding !== 2'd1) begin bad++; $display("FAIL flush_pre: got %0d want 1", outstanding); end
        rst = 1'b1;
        tick;
        rst = 1'b0; #1;
        total++; if (outstanding !== 2'd0) begin bad++; $display("FAIL flush_occ: got %0d want 0", outstanding); end
        s_rvalid = 1'b1; #1;
        total++; if (m_rvalid !== 3'b000) begin bad++; $display("FAIL flush_rvalid: got %b want 000", m_rvalid); end
        tick;
        s_rvalid = 1'b0; #1;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL flush_err: got %b want 1", err); end
    endtask

    initial begin
        test_reset;
`ifdef OBI_ARB_FIXED_PRIO_EN
        test_fixed_prio;
`else
        test_round_robin;
`endif
        test_lock;
        test_single;
        test_write_mux;
        test_throttle;
        test_unexpected_rsp;
        test_reset_flush;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Parametrised N-to-1 OBI arbiter that merges the core instruction port, core data port and coprocessor memory requests onto a single OBI memory port. It tracks outstanding transactions in an in-order routing FIFO, so each `s_rvalid_i` response is returned to the requester that issued it. It sits between `cv32e40x_core`/`coproc` and the shared memory subsystem in the top level.

## Interface
Parameters:
- `NUM_PORTS`, 3: number of requester ports; ≥2.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; byte enable width `BE_W = DATA_WIDTH/8`.
- `MAX_OUTSTANDING`, 2: routing FIFO depth; ≥1, need not be a power of two.

Ports:
- `clk_i` in 1: clock; all logic is on the rising edge.
- `rst_i` in 1: reset; synchronous, active-high.
- `m_req_i` in NUM_PORTS: per-port request.
- `m_gnt_o` out NUM_PORTS: per-port grant.
- `m_addr_i` in NUM_PORTS*ADDR_WIDTH: packed addresses; port k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `m_we_i` in NUM_PORTS: write enable.
- `m_be_i` in NUM_PORTS*BE_W: byte enables.
- `m_wdata_i` in NUM_PORTS*DATA_WIDTH: write data.
- `m_rvalid_o` out NUM_PORTS: per-port response valid.
- `m_rdata_o` out NUM_PORTS*DATA_WIDTH: read data, broadcast `s_rdata_i` to all ports.
- `s_req_o`, `s_addr_o`, `s_we_o`, `s_be_o`, `s_wdata_o` out: memory-side request, with widths 1/ADDR_WIDTH/1/BE_W/DATA_WIDTH.
- `s_gnt_i`, `s_rvalid_i` in 1; `s_rdata_i` in DATA_WIDTH: memory-side grant and response.
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): FIFO occupancy.
- `err_o` out 1: sticky error, set on an unexpected response.

## Operation
- Arbitration is round-robin. The priority pointer `rr_q` starts at 0. After a handshake on port k, `rr_q` becomes (k+1) mod NUM_PORTS. The first requesting port at or after `rr_q` (with wrap-around) wins.
- Lock: once `s_req_o` is high without `s_gnt_i`, the selected index is registered in `lock_idx_q` and `locked_q` is set. While locked, the selection is forced to `lock_idx_q` regardless of other requests, which keeps the OBI address phase stable. The lock clears on the handshake cycle.
- Handshake happens when `s_req_o && s_gnt_i`.
  - `m_gnt_o[sel] = s_gnt_i`; all other grants are 0.
  - The selected index is pushed into the routing FIFO.
- Throttle: when occupancy equals MAX_OUTSTANDING, `s_req_o = 0` and all `m_gnt_o = 0`. There is no same-cycle pop bypass.
- Response: when `s_rvalid_i` is high and the FIFO is non-empty, the head entry is popped and `m_rvalid_o[head] = 1`.
- Push and pop in the same cycle leave occupancy unchanged; both pointers advance and wrap at MAX_OUTSTANDING.
- Unexpected response (`s_rvalid_i` with FIFO empty):
  - The response is dropped and no `m_rvalid_o` is asserted.
  - `err_o` is set and stays set until `rst_i`.
- The `s_*` request fields are muxed from the selected port. When no port is selected, `s_req_o = 0` and the other `s_*` fields are driven to 0.

## Timing
- The address phase is combinational: `m_req_i` → `s_req_o` and `s_gnt_i` → `m_gnt_o` in the same cycle, with 0 added latency.
- The response path is combinational: `s_rvalid_i` → `m_rvalid_o` in the same cycle.
- A FIFO push is visible in `outstanding_o` on the next cycle.
- Reset values:
  - `rr_q = 0`, `locked_q = 0`, FIFO pointers 0, `outstanding_o = 0`, `err_o = 0`.
  - `s_req_o`, `m_gnt_o` and `m_rvalid_o` are 0 while `rst_i` is high.
- Reset mid-transaction flushes the FIFO and the lock. Responses to pre-reset requests that arrive afterwards set `err_o`; system reset must therefore cover the memory side too.
- Back-to-back: a port can be granted every cycle while the FIFO is not full.

## Configuration
- `OBI_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority, lowest index wins, and `rr_q` is not implemented. The lock rule still applies.
  - Undefined (default): round-robin as described above.

## Test plan
- Single port: port 1 issues a read to 0x0200_0000 with `s_gnt_i=1`. Expect `m_gnt_o=3'b010` in the same cycle, `outstanding_o=1` next cycle, then a response with rdata 0xDEADBEEF gives `m_rvalid_o=3'b010` and `outstanding_o=0`.
- Round-robin fairness: all 3 ports request continuously and responses return every cycle. The grant sequence must be 0,1,2,0,1,2.
- Lock: port 2 requests with `s_gnt_i=0` for 3 cycles, then port 0 raises `req`. `s_addr_o` stays on port 2's address until the grant, and port 2 is granted first.
- Full throttle: with MAX_OUTSTANDING=2, two handshakes happen with no response. A third request sees `s_req_o=0`. One `s_rvalid_i` arrives, and the grant follows on the next cycle.
- Out-of-band response: `s_rvalid_i=1` with the FIFO empty gives `m_rvalid_o=0` and `err_o=1`, which stays high until `rst_i`.
- Fixed priority: with `OBI_ARB_FIXED_PRIO_EN` defined and ports 0 and 2 requesting continuously, port 0 is always granted.
